alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_pkg.sv | 38 +++
 rtl/lsb_prio_enc.sv | 27 ++
 rtl/alu_op_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_pkg.sv
// Shared encodings for the ALU operation sequencer: operation codes,
// source-select values and FSM states.
package alu_op_pkg;

  localparam int OP_W = 4;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_EOR = 4'd1,
    OP_SUB = 4'd2,
    OP_RSB = 4'd3,
    OP_ADD = 4'd4,
    OP_ADC = 4'd5,
    OP_SBC = 4'd6,
    OP_RSC = 4'd7,
    OP_TST = 4'd8,
    OP_TEQ = 4'd9,
    OP_CMP = 4'd10,
    OP_CMN = 4'd11,
    OP_ORR = 4'd12,
    OP_MOV = 4'd13,
    OP_BIC = 4'd14,
    OP_MVN = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_IR    = 2'd0,
    SEL_CS    = 2'd1,
    SEL_ADDR  = 2'd2,
    SEL_BURST = 2'd3
  } op_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index, one-hot clear mask and a flag that
// is high when exactly one bit of the input is set.
module lsb_prio_enc #(
  parameter int LIST_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic [LIST_W-1:0] vec,
  output logic [IDX_W-1:0]  idx,
  output logic [LIST_W-1:0] clr_mask,
  output logic              single
);

  logic [LIST_W-1:0] vec_m1;

  // Two's-complement trick isolates the lowest set bit; zero input gives zero mask.
  assign clr_mask = vec & (~vec + LIST_W'(1));
  assign vec_m1   = vec - LIST_W'(1);
  assign single   = (vec != '0) && ((vec & vec_m1) == '0);

  always_comb begin
    idx = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU operation select with an LDM/STM burst walker that emits one
// address step per register in the list.
//   state | meaning
//   IDLE  | per-cycle select from IR / CS / U-bit; accepts burst start
//   RUN   | burst in progress, one beat per adv
module alu_op_sequencer #(
  parameter int              OP_W   = 4,
  parameter int              LIST_W = 16,
  parameter int              IDX_W  = 4,
  parameter logic [OP_W-1:0] ADD_OP = 4'd4,
  parameter logic [OP_W-1:0] SUB_OP = 4'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op_sel,
  input  logic [OP_W-1:0]   ir_op,
  input  logic [OP_W-1:0]   cs_op,
  input  logic              u,
  input  logic              start,
  input  logic [LIST_W-1:0] reg_list,
  input  logic              adv,
  output logic [OP_W-1:0]   alu_operation,
  output logic              op_valid,
  output logic              busy,
  output logic [IDX_W-1:0]  beat_idx,
  output logic              last_beat,
  output logic              done
);

  import alu_op_pkg::*;

  seq_state_e        state_q, state_d;
  logic [LIST_W-1:0] rem_q, rem_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [IDX_W-1:0]  low_idx;
  logic [LIST_W-1:0] low_mask;
  logic              low_single;

  lsb_prio_enc #(
    .LIST_W (LIST_W),
    .IDX_W  (IDX_W)
  ) u_enc (
    .vec      (rem_q),
    .idx      (low_idx),
    .clr_mask (low_mask),
    .single   (low_single)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (op_sel)
          SEL_IR: begin
            op_d    = ir_op;
            valid_d = 1'b1;
          end
          SEL_CS: begin
            op_d    = cs_op;
            valid_d = 1'b1;
          end
          SEL_ADDR: begin
            op_d    = u ? SUB_OP : ADD_OP;
            valid_d = 1'b1;
          end
          default: begin
            valid_d = 1'b0;
            if (start) begin
              if (reg_list != '0) begin
                // U is captured once here; op_q then holds it for the burst.
                rem_d   = reg_list;
                op_d    = u ? SUB_OP : ADD_OP;
                valid_d = 1'b1;
                state_d = RUN;
              end else begin
                done_d = 1'b1;
              end
            end
          end
        endcase
      end
      RUN: begin
        if (adv) begin
          rem_d = rem_q & ~low_mask;
          if (low_single) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Remaining list is zero outside RUN, so beat_idx/last_beat read 0 in IDLE.
  assign alu_operation = op_q;
  assign op_valid      = valid_q;
  assign busy          = (state_q == RUN);
  assign beat_idx      = low_idx;
  assign last_beat     = low_single;
  assign done          = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op_sel;
  logic [3:0]  ir_op;
  logic [3:0]  cs_op;
  logic        u;
  logic        start;
  logic [15:0] reg_list;
  logic        adv;
  logic [3:0]  alu_operation;
  logic        op_valid;
  logic        busy;
  logic [3:0]  beat_idx;
  logic        last_beat;
  logic        done;

  int asserts = 0;
  int fails   = 0;

  alu_op_sequencer #(
    .OP_W   (4),
    .LIST_W (16),
    .IDX_W  (4),
    .ADD_OP (4'd4),
    .SUB_OP (4'd2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .op_sel        (op_sel),
    .ir_op         (ir_op),
    .cs_op         (cs_op),
    .u             (u),
    .start         (start),
    .reg_list      (reg_list),
    .adv           (adv),
    .alu_operation (alu_operation),
    .op_valid      (op_valid),
    .busy          (busy),
    .beat_idx      (beat_idx),
    .last_beat     (last_beat),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Packed view {alu_operation, op_valid, busy, beat_idx, last_beat, done}
  logic [11:0] obs;
  assign obs = {alu_operation, op_valid, busy, beat_idx, last_beat, done};

  function automatic logic [11:0] ev(input logic [3:0] op, input logic vld,
                                     input logic bsy, input logic [3:0] idx,
                                     input logic lst, input logic dn);
    return {op, vld, bsy, idx, lst, dn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    rst = 1'b1; op_sel = 2'd3; ir_op = '0; cs_op = '0; u = 1'b0;
    start = 1'b0; reg_list = '0; adv = 1'b0;
    step(); step();
    exp = ev(4'h0, 0, 0, 4'h0, 0, 0);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL reset_init obs=%h exp=%h", obs, exp); fails++;
    end
    rst = 1'b0; start = 1'b1; reg_list = 16'h00F0; u = 1'b1;
    step();
    start = 1'b0;
    exp = ev(4'h2, 1, 1, 4'h4, 0, 0);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL reset_burst_start obs=%h exp=%h", obs, exp); fails++;
    end
    adv = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0; adv = 1'b0;
    exp = ev(4'h0, 0, 0, 4'h0, 0, 0);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL reset_mid_burst obs=%h exp=%h", obs, exp); fails++;
    end
    step();
    exp = ev(4'h0, 0, 0, 4'h0, 0, 0);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL reset_no_done obs=%h exp=%h", obs, exp); fails++;
    end
  endtask

  task automatic test_source_select();
    logic [1:0]  sel_t [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [3:0]  ir_t  [4] = '{4'hD, 4'h9, 4'h7, 4'h7};
    logic [3:0]  cs_t  [4] = '{4'h1, 4'h3, 4'h5, 4'h5};
    logic        u_t   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  op_t  [4] = '{4'hD, 4'h3, 4'h2, 4'h4};
    logic [11:0] exp;
    for (int i = 0; i < 4; i++) begin
      op_sel = sel_t[i]; ir_op = ir_t[i]; cs_op = cs_t[i]; u = u_t[i];
      step();
      exp = ev(op_t[i], 1, 0, 4'h0, 0, 0);
      asserts++;
      if (obs !== exp) begin
        $display("FAIL select_%0d obs=%h exp=%h", i, obs, exp); fails++;
      end
    end
    op_sel = 2'd3;
    step();
    exp = ev(4'h4, 0, 0, 4'h0, 0, 0);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL select_burst_idle_hold obs=%h exp=%h", obs, exp); fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  idx_t [3] = '{4'd0, 4'd4, 4'd15};
    logic        lst_t [3] = '{1'b0, 1'b0, 1'b1};
    logic [11:0] exp;
    op_sel = 2'd3; start = 1'b1; reg_list = 16'h8011; u = 1'b0; adv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      exp = ev(4'h4, 1, 1, idx_t[i], lst_t[i], 0);
      asserts++;
      if (obs !== exp) begin
        $display("FAIL b2b_beat_%0d obs=%h exp=%h", i, obs, exp); fails++;
      end
    end
    step();
    adv = 1'b0;
    exp = ev(4'h4, 0, 0, 4'h0, 0, 1);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL b2b_done obs=%h exp=%h", obs, exp); fails++;
    end
    step();
    exp = ev(4'h4, 0, 0, 4'h0, 0, 0);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL b2b_done_pulse obs=%h exp=%h", obs, exp); fails++;
    end
  endtask

  task automatic test_stalls();
    logic [11:0] exp;
    op_sel = 2'd3; start = 1'b1; reg_list = 16'h0006; u = 1'b1; adv = 1'b0;
    step();
    // Mid-burst start/op_sel/u/reg_list changes must all be ignored.
    reg_list = 16'hFFFF; u = 1'b0; op_sel = 2'd0; ir_op = 4'hA;
    for (int i = 0; i < 4; i++) begin
      exp = ev(4'h2, 1, 1, 4'h1, 0, 0);
      asserts++;
      if (obs !== exp) begin
        $display("FAIL stall_hold_%0d obs=%h exp=%h", i, obs, exp); fails++;
      end
      if (i < 3) step();
    end
    adv = 1'b1;
    step();
    adv = 1'b0;
    exp = ev(4'h2, 1, 1, 4'h2, 1, 0);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL stall_last obs=%h exp=%h", obs, exp); fails++;
    end
    step();
    asserts++;
    if (obs !== exp) begin
      $display("FAIL stall_last_hold obs=%h exp=%h", obs, exp); fails++;
    end
    start = 1'b0; op_sel = 2'd3; adv = 1'b1;
    step();
    adv = 1'b0;
    exp = ev(4'h2, 0, 0, 4'h0, 0, 1);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL stall_done obs=%h exp=%h", obs, exp); fails++;
    end
    step();
  endtask

  task automatic test_empty();
    logic [11:0] exp;
    op_sel = 2'd3; start = 1'b1; reg_list = 16'h0000; u = 1'b0; adv = 1'b1;
    step();
    start = 1'b0;
    exp = ev(4'h2, 0, 0, 4'h0, 0, 1);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL empty_done obs=%h exp=%h", obs, exp); fails++;
    end
    step();
    adv = 1'b0;
    exp = ev(4'h2, 0, 0, 4'h0, 0, 0);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL empty_after obs=%h exp=%h", obs, exp); fails++;
    end
  endtask

  task automatic test_restart();
    logic [11:0] exp;
    op_sel = 2'd3; start = 1'b1; reg_list = 16'h0001; u = 1'b1; adv = 1'b0;
    step();
    start = 1'b0; adv = 1'b1;
    step();
    exp = ev(4'h2, 0, 0, 4'h0, 0, 1);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL restart_first_done obs=%h exp=%h", obs, exp); fails++;
    end
    start = 1'b1; reg_list = 16'h0001; u = 1'b0; adv = 1'b0;
    step();
    start = 1'b0;
    exp = ev(4'h4, 1, 1, 4'h0, 1, 0);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL restart_accept obs=%h exp=%h", obs, exp); fails++;
    end
    adv = 1'b1;
    step();
    adv = 1'b0;
    exp = ev(4'h4, 0, 0, 4'h0, 0, 1);
    asserts++;
    if (obs !== exp) begin
      $display("FAIL restart_done obs=%h exp=%h", obs, exp); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_source_select();
    test_back_to_back();
    test_stalls();
    test_empty();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
